// File: rtl/ex_mem_result_stage_if.sv
// EX->MEM result stage bus: EX-side inputs, hazard controls and registered stage outputs.
// The master drives EX/hazard signals; the slave (the stage) drives the registered outputs.
interface ex_mem_result_stage_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned REG_AW = 4
);
   logic              valid_in;
   logic [3:0]        opcode_in;
   logic [DATA_W-1:0] alu_res_in;
   logic              alu_ovfl_in;
   logic [REG_AW-1:0] rd_in;
   logic              wen_in;
   logic              stall;
   logic              flush;

   logic              valid_q;
   logic [DATA_W-1:0] res_q;
   logic [REG_AW-1:0] rd_q;
   logic              wen_q;
   logic              flag_z;
   logic              flag_v;
   logic              flag_n;

   modport master (
      output valid_in, opcode_in, alu_res_in, alu_ovfl_in, rd_in, wen_in, stall, flush,
      input  valid_q, res_q, rd_q, wen_q, flag_z, flag_v, flag_n
   );

   modport slave (
      input  valid_in, opcode_in, alu_res_in, alu_ovfl_in, rd_in, wen_in, stall, flush,
      output valid_q, res_q, rd_q, wen_q, flag_z, flag_v, flag_n
   );
endinterface

// File: rtl/ex_mem_result_stage.sv
// EX->MEM pipeline register for ALU results plus the architectural Z/V/N flag register.
// Flush beats stall beats capture; flags change only on capture of a flag-setting opcode.
module ex_mem_result_stage #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned REG_AW = 4
) (
   input logic                  clk,
   input logic                  rst,
   ex_mem_result_stage_if.slave bus
);

   typedef enum logic [3:0] {
      OpAdd    = 4'b0000,
      OpSub    = 4'b0001,
      OpXor    = 4'b0010,
      OpRed    = 4'b0011,
      OpSll    = 4'b0100,
      OpSra    = 4'b0101,
      OpRor    = 4'b0110,
      OpPaddsb = 4'b0111
   } alu_op_e;

   logic              stage_valid_q, stage_valid_d;
   logic [DATA_W-1:0] stage_res_q, stage_res_d;
   logic [REG_AW-1:0] stage_rd_q, stage_rd_d;
   logic              stage_wen_q, stage_wen_d;
   logic              z_q, z_d;
   logic              v_q, v_d;
   logic              n_q, n_d;

   logic capture;
   logic upd_znv;
   logic upd_z;
   logic res_zero;

   assign capture  = bus.valid_in & ~bus.stall & ~bus.flush;
   assign res_zero = (bus.alu_res_in == '0);

   // Opcodes >= 1000 are non-ALU and never touch the flags.
   always_comb begin
      upd_znv = 1'b0;
      upd_z   = 1'b0;
      case (bus.opcode_in)
         OpAdd, OpSub:               upd_znv = 1'b1;
         OpXor, OpSll, OpSra, OpRor: upd_z   = 1'b1;
         default: begin
            upd_znv = 1'b0;
            upd_z   = 1'b0;
         end
      endcase
   end

   always_comb begin
      stage_valid_d = stage_valid_q;
      stage_res_d   = stage_res_q;
      stage_rd_d    = stage_rd_q;
      stage_wen_d   = stage_wen_q;
      z_d           = z_q;
      v_d           = v_q;
      n_d           = n_q;

      if (bus.flush) begin
         stage_valid_d = 1'b0;
         stage_wen_d   = 1'b0;
      end else if (!bus.stall) begin
         if (capture) begin
            stage_valid_d = 1'b1;
            stage_res_d   = bus.alu_res_in;
            stage_rd_d    = bus.rd_in;
            stage_wen_d   = bus.wen_in;
            if (upd_znv) begin
               z_d = res_zero;
               v_d = bus.alu_ovfl_in;
               n_d = bus.alu_res_in[DATA_W-1];
            end else if (upd_z) begin
               z_d = res_zero;
            end
         end else begin
            stage_valid_d = 1'b0;
            stage_wen_d   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_valid_q <= 1'b0;
         stage_res_q   <= '0;
         stage_rd_q    <= '0;
         stage_wen_q   <= 1'b0;
         z_q           <= 1'b0;
         v_q           <= 1'b0;
         n_q           <= 1'b0;
      end else begin
         stage_valid_q <= stage_valid_d;
         stage_res_q   <= stage_res_d;
         stage_rd_q    <= stage_rd_d;
         stage_wen_q   <= stage_wen_d;
         z_q           <= z_d;
         v_q           <= v_d;
         n_q           <= n_d;
      end
   end

   assign bus.valid_q = stage_valid_q;
   assign bus.res_q   = stage_res_q;
   assign bus.rd_q    = stage_rd_q;
   assign bus.wen_q   = stage_wen_q & stage_valid_q;
   assign bus.flag_z  = z_q;
   assign bus.flag_v  = v_q;
   assign bus.flag_n  = n_q;

endmodule
